// File: rtl/enigma_sink_if.sv
// Port-c bundle between the merge buffer and enigma_sink.
// The sig member exists only when ENIGMA_SINK_SIG_EN is defined.
interface enigma_sink_if #(
  parameter int unsigned PW    = 128,
  parameter int unsigned IW    = 6,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          valid_c;
  logic [PW-1:0] payload_c;
  logic [IW-1:0] id_c;
  logic [1:0]    qos_c;
  logic          ready_c;
  logic          conflict_c;
  logic          release_c;
  logic [IW-1:0] releaseid_c;
  logic [CW-1:0] occupancy;
`ifdef ENIGMA_SINK_SIG_EN
  logic [31:0]   sig;
`endif

  modport master (
    output valid_c, payload_c, id_c, qos_c,
    input  ready_c, conflict_c, release_c, releaseid_c, occupancy
`ifdef ENIGMA_SINK_SIG_EN
    , input sig
`endif
  );

  modport slave (
    input  valid_c, payload_c, id_c, qos_c,
    output ready_c, conflict_c, release_c, releaseid_c, occupancy
`ifdef ENIGMA_SINK_SIG_EN
    , output sig
`endif
  );
endinterface

// File: rtl/enigma_sink.sv
// Port-c consumer: busy-map conflict detection, fixed-latency in-order retire.
// Optional payload signature enabled by ENIGMA_SINK_SIG_EN.
module enigma_sink #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned PW      = 128,
  parameter int unsigned IW      = 6
) (
  input logic         clk,
  input logic         rst_n,
  enigma_sink_if.slave bus
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [7:0]  AGE_MIN = 8'(LATENCY - 1);

  logic [IW-1:0]      r_fifo_id [DEPTH];
  logic [7:0]         r_fifo_ts [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [7:0]         r_now;
  logic [(1<<IW)-1:0] r_busy;
  logic               r_release;
  logic [IW-1:0]      r_release_id;

  logic               w_ready;
  logic               w_busy_hit;
  logic               w_accept;
  logic               w_retire;
  logic [IW-1:0]      w_head_id;
  logic [7:0]         w_age;

  // Age is taken mod 256; an entry never waits longer than LATENCY, so no aliasing.
  always_comb begin
    w_ready    = (r_count != CW'(DEPTH));
    w_busy_hit = r_busy[bus.id_c];
    w_accept   = bus.valid_c & w_ready & ~w_busy_hit;
    w_head_id  = r_fifo_id[r_rd_ptr];
    w_age      = r_now - r_fifo_ts[r_rd_ptr];
    w_retire   = (r_count != '0) && (w_age >= AGE_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_now        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_busy       <= '0;
      r_release    <= 1'b0;
      r_release_id <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_fifo_id[i] <= '0;
        r_fifo_ts[i] <= '0;
      end
    end else begin
      r_now <= r_now + 8'd1;
      if (w_accept) begin
        r_fifo_id[r_wr_ptr] <= bus.id_c;
        r_fifo_ts[r_wr_ptr] <= r_now;
        r_wr_ptr            <= r_wr_ptr + AW'(1);
        r_busy[bus.id_c]    <= 1'b1;
      end
      // Accept and retire never target the same busy bit in one cycle.
      if (w_retire) begin
        r_rd_ptr          <= r_rd_ptr + AW'(1);
        r_busy[w_head_id] <= 1'b0;
        r_release_id      <= w_head_id;
      end
      r_release <= w_retire;
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    bus.ready_c     = w_ready;
    bus.conflict_c  = bus.valid_c & w_ready & w_busy_hit;
    bus.release_c   = r_release;
    bus.releaseid_c = r_release_id;
    bus.occupancy   = r_count;
  end

`ifdef ENIGMA_SINK_SIG_EN
  logic [31:0] r_sig;
  logic [31:0] w_fold;

  always_comb begin
    w_fold = '0;
    for (int unsigned i = 0; i < PW / 32; i++) begin
      w_fold = w_fold ^ bus.payload_c[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (w_accept) begin
      r_sig <= {r_sig[30:0], r_sig[31]} ^ w_fold ^ 32'({bus.qos_c, bus.id_c});
    end
  end

  always_comb bus.sig = r_sig;
`else
  logic w_unused;
  always_comb w_unused = ^{bus.qos_c, bus.payload_c};
`endif
endmodule

// File: tb/tb_enigma_sink.sv
// Scoreboard bench for enigma_sink: DUT A (DEPTH 8, LATENCY 4), DUT B (DEPTH 8, LATENCY 20).
// Signature checks compile in when ENIGMA_SINK_SIG_EN is defined.
module tb_enigma_sink;
  localparam int unsigned LAT_A = 4;
  localparam int unsigned LAT_B = 20;

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] exp_sig_a = '0;

  enigma_sink_if #(.PW(128), .IW(6), .DEPTH(8)) ifa ();
  enigma_sink_if #(.PW(128), .IW(6), .DEPTH(8)) ifb ();

  enigma_sink #(.DEPTH(8), .LATENCY(LAT_A), .PW(128), .IW(6)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  enigma_sink #(.DEPTH(8), .LATENCY(LAT_B), .PW(128), .IW(6)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sig_next(input logic [31:0] s, input logic [127:0] pl,
                                           input logic [1:0] q, input logic [5:0] id);
    logic [31:0] f;
    f = {s[30:0], s[31]} ^ {24'd0, q, id};
    for (int i = 0; i < 4; i++) f = f ^ pl[i*32 +: 32];
    return f;
  endfunction

  // A transfer driven while cyc=E is accepted at edge E+1 and released when cyc=E+LATENCY.
  task automatic drive_a(input logic [5:0] id, input logic [127:0] pl, input logic [1:0] qos,
                         input bit exp_conf);
    @(negedge clk);
`ifdef ENIGMA_SINK_SIG_EN
    check("sig_a", ifa.sig, exp_sig_a);
`endif
    ifa.valid_c   = 1'b1;
    ifa.id_c      = id;
    ifa.payload_c = pl;
    ifa.qos_c     = qos;
    #1;
    check("ready_a", ifa.ready_c, 1);
    check("conflict_a", ifa.conflict_c, exp_conf);
    if (!exp_conf) begin
      qa.push_back('{id: id, due: cyc + LAT_A});
      exp_sig_a = sig_next(exp_sig_a, pl, qos, id);
    end
  endtask

  task automatic idle_a(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      ifa.valid_c = 1'b0;
      #1;
    end
  endtask

  task automatic drive_b(input logic [5:0] id, input bit exp_rdy);
    @(negedge clk);
    ifb.valid_c   = 1'b1;
    ifb.id_c      = id;
    ifb.payload_c = {4{32'hA5A5_0000 | 32'(id)}};
    ifb.qos_c     = 2'd1;
    #1;
    check("ready_b", ifb.ready_c, exp_rdy);
    check("conflict_b", ifb.conflict_c, 0);
    if (exp_rdy) qb.push_back('{id: id, due: cyc + LAT_B});
  endtask

  task automatic idle_b(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      ifb.valid_c = 1'b0;
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() != 0 && qa[0].due == cyc) begin
      check("release_a", ifa.release_c, 1);
      check("releaseid_a", ifa.releaseid_c, qa[0].id);
      void'(qa.pop_front());
    end else if (ifa.release_c) begin
      check("release_extra_a", ifa.release_c, 0);
    end
  end

  always @(negedge clk) begin
    if (qb.size() != 0 && qb[0].due == cyc) begin
      check("release_b", ifb.release_c, 1);
      check("releaseid_b", ifb.releaseid_c, qb[0].id);
      void'(qb.pop_front());
    end else if (ifb.release_c) begin
      check("release_extra_b", ifb.release_c, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    ifa.valid_c = 1'b0; ifa.id_c = '0; ifa.payload_c = '0; ifa.qos_c = '0;
    ifb.valid_c = 1'b0; ifb.id_c = '0; ifb.payload_c = '0; ifb.qos_c = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", ifa.ready_c, 1);
    check("rst_conflict", ifa.conflict_c, 0);
    check("rst_release", ifa.release_c, 0);
    check("rst_releaseid", ifa.releaseid_c, 0);
    check("rst_occupancy", ifa.occupancy, 0);
    check("rst_ready_b", ifb.ready_c, 1);
`ifdef ENIGMA_SINK_SIG_EN
    check("rst_sig", ifa.sig, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // First transfer from reset: all-ones payload folds to zero.
    drive_a(6'd1, '1, 2'd0, 1'b0);
    idle_a(1);
`ifdef ENIGMA_SINK_SIG_EN
    check("sig_first", ifa.sig, 32'h0000_0001);
`endif
    idle_a(6);
    check("occ_drain0", ifa.occupancy, 0);

    drive_a(6'd5, 128'h1234, 2'd2, 1'b0);
    idle_a(1);
    check("occ_single1", ifa.occupancy, 1);
    idle_a(5);
    check("occ_single0", ifa.occupancy, 0);

    // Re-present id 7 until busy clears; acceptance lands in the release cycle.
    drive_a(6'd7, 128'h77, 2'd3, 1'b0);
    for (int j = 1; j <= int'(LAT_A); j++) begin
      drive_a(6'd7, 128'h77, 2'd3, (j < int'(LAT_A)));
      if (j < int'(LAT_A)) check("occ_conflict", ifa.occupancy, 1);
    end
    idle_a(6);
    check("occ_drain1", ifa.occupancy, 0);

    for (int i = 0; i < 64; i++) begin
      drive_a(6'(i), {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(3)), 1'b0);
    end
    idle_a(8);
    check("occ_stream", ifa.occupancy, 0);

    // Full: 8 accepts fill B; the first retire reopens it at relative cycle 20.
    n = 0;
    for (int j = 0; j < 40 && n < 10; j++) begin
      drive_b(6'(n), (j < 8) || (j >= 20));
      if ((j < 8) || (j >= 20)) n++;
      if (j == 10) check("occ_full_b", ifb.occupancy, 8);
    end
    idle_b(LAT_B + 4);
    check("occ_drain_b", ifb.occupancy, 0);

    drive_a(6'd10, 128'hA, 2'd0, 1'b0);
    drive_a(6'd11, 128'hB, 2'd1, 1'b0);
    drive_a(6'd12, 128'hC, 2'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    ifa.valid_c = 1'b0;
    #1;
    qa.delete();
    exp_sig_a = '0;
    check("midrst_ready", ifa.ready_c, 1);
    check("midrst_conflict", ifa.conflict_c, 0);
    check("midrst_release", ifa.release_c, 0);
    check("midrst_releaseid", ifa.releaseid_c, 0);
    check("midrst_occupancy", ifa.occupancy, 0);
`ifdef ENIGMA_SINK_SIG_EN
    check("midrst_sig", ifa.sig, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_a(8);
    drive_a(6'd10, 128'hD, 2'd0, 1'b0);
    idle_a(6);
    check("occ_final", ifa.occupancy, 0);
    check("queue_a_empty", qa.size(), 0);
    check("queue_b_empty", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
